mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch port and its load/store data port.
- Accepts a request/valid transaction from each requester and serialises them onto the shared memory port.
- Arbitrates conflicts round-robin and returns read data with a one-cycle valid pulse.
- Includes a memory-timeout watchdog and misaligned-fetch rejection, so the core never hangs on a dead bus.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT_CYCLES, 16, maximum BUSY cycles waiting for mem_valid before an error response (must be ≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- if_request  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word
- if_valid  out  1  one-cycle fetch-done pulse
- if_err  out  1  qualifies if_valid: misaligned fetch or timeout
- dm_request  in  1  data request; held until dm_valid
- dm_we_re  in  1  1 = store, 0 = load
- dm_mask  in  4  byte enables
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data (0 for stores)
- dm_valid  out  1  one-cycle data-done pulse
- dm_err  out  1  qualifies dm_valid: timeout
- mem_request  out  1  shared memory request
- mem_we_re  out  1  shared memory write enable
- mem_mask  out  4  shared memory byte enables
- mem_addr  out  ADDR_W  shared memory address
- mem_wdata  out  DATA_W  shared memory write data
- mem_rdata  in  DATA_W  shared memory read data
- mem_valid  in  1  memory completion, sampled only in BUSY
- busy  out  1  high in BUSY or RESP

Behaviour:
- Reset:
  - Clock and reset: clk is the single clock; rst is synchronous and active-low.
  - When rst is sampled low, all of the following hold at the next edge: state = IDLE; every output = 0; last_grant = FETCH; timeout counter = 0.
  - Reset mid-transaction abandons the transaction. No valid pulse is issued for it.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant the port not in last_grant (first conflict after reset → DATA).
  - On grant, register addr/we_re/mask/wdata into the mem_* outputs and record the grant.
  - Go to BUSY with mem_request = 1 from the next cycle.
  - Fetch requests drive we_re = 0 and mask = 4'b1111.
  - Misaligned fetch (if_addr[1:0] ≠ 0) is granted but goes straight to RESP with if_err = 1 and if_rdata = 0. The memory is not accessed.
- BUSY:
  - mem_request and the mem_* outputs stay stable.
  - Counter increments each cycle.
  - mem_valid = 1: capture mem_rdata (loads/fetches only; stores return 0), clear mem_request, go to RESP.
  - Counter reaching TIMEOUT_CYCLES−1 without mem_valid: clear mem_request, rdata = 0, err = 1, go to RESP.
  - mem_valid on the timeout cycle: mem_valid wins and err = 0.
- RESP:
  - Exactly one cycle.
  - The granted port's valid = 1, with its rdata/err.
  - last_grant is updated to the granted port.
  - Requests are ignored this cycle. Next state is IDLE.
- Latency:
  - Request seen in IDLE at cycle N → mem_request high from N+1.
  - mem_valid at cycle M → port valid at M+1.
  - Earliest next grant at M+2.
  - Zero-wait memory (mem_valid in the first BUSY cycle) gives 3 cycles per transaction.
- Requester rule: after sampling valid, a requester either deasserts its request or presents a new one. A request held high continuously re-issues.
- mem_valid in IDLE or RESP is ignored; it produces no pulse and no state change.
- rdata/err outputs hold their value after the pulse until the next RESP for that port. valid is the only strobe.

Decomposition:
- Shared package/include mem_arb_pkg:
  - state encodings IDLE/BUSY/RESP
  - grant encoding FETCH = 0, DATA = 1
  - FETCH_MASK = 4'b1111
- One sub-module: arb_rr2.
  - Combinational two-requester round-robin picker.
  - Inputs: req[1:0], last_grant. Outputs: gnt_valid, gnt_id.
  - Instantiated in IDLE grant logic.

Test Plan:
- Fetch only, if_addr = 0x0000_0010; memory replies mem_valid one cycle after mem_request with 0x0000_0093:
  - mem_addr = 0x10, mem_mask = 4'hF, mem_we_re = 0.
  - if_valid pulses once with if_rdata = 0x0000_0093, if_err = 0.
- Simultaneous fetch (0x20) and store (dm_addr = 0x100, wdata = 0xDEADBEEF, mask = 4'b0011) right after reset:
  - Store granted first with mem_we_re = 1, mem_mask = 4'b0011.
  - Fetch granted on the next IDLE.
  - dm_valid precedes if_valid; dm_rdata = 0.
- Both requesters held high for 6 transactions, zero-wait memory: grants alternate D,F,D,F,D,F at a 3-cycle cadence.
- Memory never asserts mem_valid, TIMEOUT_CYCLES = 16, load from 0x200:
  - mem_request drops after 15 BUSY cycles.
  - dm_valid = 1, dm_err = 1, dm_rdata = 0.
  - A subsequent fetch completes normally.
- Fetch at if_addr = 0x0000_0006:
  - mem_request never asserts.
  - if_valid = 1 and if_err = 1 two cycles after the request.
- rst low during BUSY:
  - Next edge gives IDLE, mem_request = 0, no valid pulse.
  - A late mem_valid is ignored.
  - After release, the first conflict grants DATA.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
//   state_t    : arbiter FSM states
//   grant_t    : requester identity (FETCH = 0, DATA = 1)
//   FETCH_MASK : byte enables used for every instruction fetch
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } grant_t;

   localparam logic [3:0] FETCH_MASK = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, data port and shared memory port.
//   master : arbiter view (serves the two requesters, drives the memory)
//   slave  : environment view (requesters plus memory)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_request;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              if_err;

   logic              dm_request;
   logic              dm_we_re;
   logic [3:0]        dm_mask;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              dm_err;

   logic              mem_request;
   logic              mem_we_re;
   logic [3:0]        mem_mask;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;

   modport master (
      input  if_request, if_addr,
      output if_rdata, if_valid, if_err,
      input  dm_request, dm_we_re, dm_mask, dm_addr, dm_wdata,
      output dm_rdata, dm_valid, dm_err,
      output mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata,
      input  mem_rdata, mem_valid
   );

   modport slave (
      output if_request, if_addr,
      input  if_rdata, if_valid, if_err,
      output dm_request, dm_we_re, dm_mask, dm_addr, dm_wdata,
      input  dm_rdata, dm_valid, dm_err,
      input  mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata,
      output mem_rdata, mem_valid
   );
endinterface

// File: rtl/arb_rr2.sv
// Combinational two-requester round-robin picker.
//   req[0]     : fetch request, req[1] : data request
//   last_grant : requester served most recently
//   gnt_valid  : at least one request present
//   gnt_id     : chosen requester; on conflict the one not in last_grant
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last_grant,
   output logic       gnt_valid,
   output grant_t     gnt_id
);

   always_comb begin
      gnt_valid = |req;
      gnt_id    = FETCH;
      if (&req) begin
         gnt_id = (last_grant == FETCH) ? DATA : FETCH;
      end else if (req[1]) begin
         gnt_id = DATA;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store requests onto one single-ported
// memory, with round-robin conflict resolution, a completion watchdog and
// rejection of misaligned fetches.
//   clk  : system clock
//   rst  : synchronous, active-low reset
//   bus  : fetch / data / memory signals (master modport)
//   busy : high while a transaction is in BUSY or RESP
//
//   state | meaning
//   IDLE  | waiting for a request; grants and registers the memory command
//   BUSY  | memory request outstanding; watchdog counting
//   RESP  | one-cycle valid pulse to the granted port; last_grant updated
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.master bus,
   output logic               busy
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
   // Last BUSY cycle: the counter would reach TIMEOUT_CYCLES-1 on this edge.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   state_t            state, state_nxt;
   grant_t            grant_id, last_grant, gnt_id, finish_id;
   logic              gnt_valid;
   logic [CNT_W-1:0]  cnt;

   logic              start_mem, finish, finish_err;
   logic [DATA_W-1:0] finish_rdata;

   logic              mem_request_q, mem_we_re_q;
   logic [3:0]        mem_mask_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
   logic              if_valid_q, if_err_q, dm_valid_q, dm_err_q;

   arb_rr2 u_arb (
      .req        ({bus.dm_request, bus.if_request}),
      .last_grant (last_grant),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   always_comb begin
      state_nxt    = state;
      start_mem    = 1'b0;
      finish       = 1'b0;
      finish_err   = 1'b0;
      finish_rdata = '0;
      finish_id    = grant_id;
      unique case (state)
         IDLE: begin
            if (gnt_valid) begin
               finish_id = gnt_id;
               // Misaligned fetch never touches memory; answer with an error.
               if (gnt_id == FETCH && bus.if_addr[1:0] != 2'b00) begin
                  finish     = 1'b1;
                  finish_err = 1'b1;
                  state_nxt  = RESP;
               end else begin
                  start_mem = 1'b1;
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            // Completion takes priority over the watchdog on the same cycle.
            if (bus.mem_valid) begin
               finish       = 1'b1;
               finish_rdata = mem_we_re_q ? '0 : bus.mem_rdata;
               state_nxt    = RESP;
            end else if (cnt == CNT_LAST) begin
               finish     = 1'b1;
               finish_err = 1'b1;
               state_nxt  = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         grant_id      <= FETCH;
         last_grant    <= FETCH;
         cnt           <= '0;
         mem_request_q <= 1'b0;
         mem_we_re_q   <= 1'b0;
         mem_mask_q    <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_rdata_q    <= '0;
         if_valid_q    <= 1'b0;
         if_err_q      <= 1'b0;
         dm_rdata_q    <= '0;
         dm_valid_q    <= 1'b0;
         dm_err_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         cnt        <= (state == BUSY) ? cnt + CNT_W'(1) : '0;

         if (state == IDLE && gnt_valid) begin
            grant_id <= gnt_id;
         end

         if (start_mem) begin
            mem_request_q <= 1'b1;
            if (gnt_id == FETCH) begin
               mem_addr_q  <= bus.if_addr;
               mem_we_re_q <= 1'b0;
               mem_mask_q  <= FETCH_MASK;
               mem_wdata_q <= '0;
            end else begin
               mem_addr_q  <= bus.dm_addr;
               mem_we_re_q <= bus.dm_we_re;
               mem_mask_q  <= bus.dm_mask;
               mem_wdata_q <= bus.dm_wdata;
            end
         end

         if (finish) begin
            mem_request_q <= 1'b0;
            if (finish_id == FETCH) begin
               if_valid_q <= 1'b1;
               if_rdata_q <= finish_rdata;
               if_err_q   <= finish_err;
            end else begin
               dm_valid_q <= 1'b1;
               dm_rdata_q <= finish_rdata;
               dm_err_q   <= finish_err;
            end
         end

         if (state == RESP) begin
            last_grant <= grant_id;
         end
      end
   end

   assign bus.mem_request = mem_request_q;
   assign bus.mem_we_re   = mem_we_re_q;
   assign bus.mem_mask    = mem_mask_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.if_rdata    = if_rdata_q;
   assign bus.if_valid    = if_valid_q;
   assign bus.if_err      = if_err_q;
   assign bus.dm_rdata    = dm_rdata_q;
   assign bus.dm_valid    = dm_valid_q;
   assign bus.dm_err      = dm_err_q;
   assign busy            = (state == BUSY) || (state == RESP);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// memory commands and port responses; monitors pop and compare them.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } acc_t;

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   acc_t  exp_acc[$];
   resp_t exp_resp[$];
   int    rise_cyc[$];

   int   n_tests = 0, n_fail = 0;
   int   resp_count = 0, rise_count = 0, cyc = 0, req_len = 0, last_len = 0;
   logic req_prev = 1'b0, mon_en = 1'b0;
   logic mem_never = 1'b0, inject_late = 1'b0;
   int   mem_delay = 0, wait_cnt = 0;
   logic [31:0] mem_arr [0:255];
   logic [7:0]  m_idx;
   logic [31:0] m_bm;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   function automatic void push_acc(logic [31:0] a, logic w, logic [3:0] m, logic [31:0] d);
      acc_t x;
      x.addr = a; x.we = w; x.mask = m; x.wdata = d;
      exp_acc.push_back(x);
   endfunction

   function automatic void push_resp(logic p, logic [31:0] d, logic e);
      resp_t x;
      x.port = p; x.rdata = d; x.err = e;
      exp_resp.push_back(x);
   endfunction

   // memory model: answers after mem_delay BUSY cycles unless mem_never
   always @(negedge clk) begin
      if (bus.mem_request && !mem_never) begin
         if (wait_cnt >= mem_delay) begin
            m_idx = bus.mem_addr[9:2];
            bus.mem_valid = 1'b1;
            if (bus.mem_we_re) begin
               m_bm = {{8{bus.mem_mask[3]}}, {8{bus.mem_mask[2]}},
                       {8{bus.mem_mask[1]}}, {8{bus.mem_mask[0]}}};
               mem_arr[m_idx] = (mem_arr[m_idx] & ~m_bm) | (bus.mem_wdata & m_bm);
               bus.mem_rdata  = 32'hA5A5_A5A5;
            end else begin
               bus.mem_rdata = mem_arr[m_idx];
            end
         end else begin
            wait_cnt++;
            bus.mem_valid = 1'b0;
         end
      end else begin
         wait_cnt      = 0;
         bus.mem_valid = inject_late;
         bus.mem_rdata = inject_late ? 32'hBAD0_BAD0 : 32'h0;
      end
   end

   // monitor: memory commands and port responses
   always @(negedge clk) begin
      acc_t  a;
      resp_t r;
      cyc++;
      if (mon_en) begin
         if (bus.mem_request && !req_prev) begin
            rise_count++;
            rise_cyc.push_back(cyc);
            if (exp_acc.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_access: addr 0x%08h, none expected", bus.mem_addr);
            end else begin
               a = exp_acc.pop_front();
               check("acc_addr", bus.mem_addr, a.addr);
               check("acc_we", 32'(bus.mem_we_re), 32'(a.we));
               check("acc_mask", 32'(bus.mem_mask), 32'(a.mask));
               if (a.we) check("acc_wdata", bus.mem_wdata, a.wdata);
            end
         end
         if (bus.mem_request) req_len++;
         else begin
            if (req_prev) last_len = req_len;
            req_len = 0;
         end
         if (bus.if_valid || bus.dm_valid) begin
            resp_count++;
            if (bus.if_valid && bus.dm_valid) begin
               n_tests++; n_fail++;
               $display("FAIL both_valid: if_valid and dm_valid high together, expected one");
            end
            if (exp_resp.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_valid: if_valid=%0b dm_valid=%0b, none expected",
                        bus.if_valid, bus.dm_valid);
            end else begin
               r = exp_resp.pop_front();
               check("resp_port", 32'(bus.dm_valid), 32'(r.port));
               if (r.port) begin
                  check("dm_rdata", bus.dm_rdata, r.rdata);
                  check("dm_err", 32'(bus.dm_err), 32'(r.err));
               end else begin
                  check("if_rdata", bus.if_rdata, r.rdata);
                  check("if_err", 32'(bus.if_err), 32'(r.err));
               end
            end
         end
         req_prev = bus.mem_request;
      end
   end

   task automatic wait_resp(input int target, input string name, output int edges);
      edges = 0;
      while (resp_count < target) begin
         @(posedge clk);
         edges++;
         if (edges > 200) begin
            n_tests++; n_fail++;
            $display("FAIL %s: no valid within 200 cycles, got %0d of %0d", name, resp_count, target);
            break;
         end
      end
      #1;
   endtask

   task automatic gap();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.if_request = 1'b0;
      bus.dm_request = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int base, lat, rc;
      for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
      mem_arr[4] = 32'h0000_0093;   // 0x10
      mem_arr[8] = 32'h0000_0013;   // 0x20
      bus.if_request = 1'b0; bus.if_addr = '0;
      bus.dm_request = 1'b0; bus.dm_we_re = 1'b0; bus.dm_mask = '0;
      bus.dm_addr = '0; bus.dm_wdata = '0;

      // reset state
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_flags", 32'({bus.if_valid, bus.if_err, bus.dm_valid, bus.dm_err,
                              bus.mem_request, bus.mem_we_re, busy}), 32'h0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_mask", 32'(bus.mem_mask), 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_if_rdata", bus.if_rdata, 32'h0);
      check("rst_dm_rdata", bus.dm_rdata, 32'h0);
      rst = 1'b1;
      mon_en = 1'b1;
      gap();

      // fetch only, memory answers one cycle after mem_request
      mem_delay = 1;
      push_acc(32'h10, 1'b0, 4'hF, 32'h0);
      push_resp(1'b0, 32'h0000_0093, 1'b0);
      base = resp_count;
      bus.if_addr = 32'h10; bus.if_request = 1'b1;
      wait_resp(base + 1, "fetch_only", lat);
      bus.if_request = 1'b0;
      gap();

      // simultaneous store and fetch right after reset: store first
      do_reset();
      mem_delay = 0;
      push_acc(32'h100, 1'b1, 4'b0011, 32'hDEAD_BEEF);
      push_acc(32'h20, 1'b0, 4'hF, 32'h0);
      push_resp(1'b1, 32'h0, 1'b0);
      push_resp(1'b0, 32'h0000_0013, 1'b0);
      base = resp_count;
      bus.if_addr = 32'h20; bus.if_request = 1'b1;
      bus.dm_addr = 32'h100; bus.dm_we_re = 1'b1; bus.dm_mask = 4'b0011;
      bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_request = 1'b1;
      wait_resp(base + 1, "conflict_store", lat);
      bus.dm_request = 1'b0;
      wait_resp(base + 2, "conflict_fetch", lat);
      bus.if_request = 1'b0;
      gap();

      // both held: D,F,D,F,D,F every 3 cycles
      do_reset();
      rise_cyc.delete();
      for (int i = 0; i < 3; i++) begin
         push_acc(32'h100, 1'b0, 4'hF, 32'h0);
         push_acc(32'h10, 1'b0, 4'hF, 32'h0);
         push_resp(1'b1, 32'h0000_BEEF, 1'b0);
         push_resp(1'b0, 32'h0000_0093, 1'b0);
      end
      base = resp_count;
      bus.if_addr = 32'h10; bus.if_request = 1'b1;
      bus.dm_addr = 32'h100; bus.dm_we_re = 1'b0; bus.dm_mask = 4'hF;
      bus.dm_wdata = 32'h0; bus.dm_request = 1'b1;
      wait_resp(base + 6, "cadence", lat);
      bus.if_request = 1'b0; bus.dm_request = 1'b0;
      check("cadence_grants", 32'(rise_cyc.size()), 32'd6);
      for (int i = 1; i < rise_cyc.size(); i++)
         check("cadence_spacing", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd3);
      gap();

      // dead memory: watchdog error, then a normal fetch
      mem_never = 1'b1;
      push_acc(32'h200, 1'b0, 4'hF, 32'h0);
      push_resp(1'b1, 32'h0, 1'b1);
      base = resp_count;
      bus.dm_addr = 32'h200; bus.dm_we_re = 1'b0; bus.dm_mask = 4'hF;
      bus.dm_request = 1'b1;
      wait_resp(base + 1, "timeout", lat);
      bus.dm_request = 1'b0;
      check("timeout_req_len", 32'(last_len), 32'd15);
      mem_never = 1'b0;
      gap();
      push_acc(32'h20, 1'b0, 4'hF, 32'h0);
      push_resp(1'b0, 32'h0000_0013, 1'b0);
      base = resp_count;
      bus.if_addr = 32'h20; bus.if_request = 1'b1;
      wait_resp(base + 1, "after_timeout", lat);
      bus.if_request = 1'b0;
      gap();

      // misaligned fetch: no memory access, error after two cycles
      rc = rise_count;
      push_resp(1'b0, 32'h0, 1'b1);
      base = resp_count;
      bus.if_addr = 32'h6; bus.if_request = 1'b1;
      wait_resp(base + 1, "misaligned", lat);
      bus.if_request = 1'b0;
      check("misaligned_latency", 32'(lat), 32'd2);
      check("misaligned_no_access", 32'(rise_count), 32'(rc));
      gap();

      // leave last_grant = DATA, then reset during BUSY
      push_acc(32'h100, 1'b0, 4'hF, 32'h0);
      push_resp(1'b1, 32'h0000_BEEF, 1'b0);
      base = resp_count;
      bus.dm_addr = 32'h100; bus.dm_request = 1'b1;
      wait_resp(base + 1, "pre_reset_load", lat);
      bus.dm_request = 1'b0;
      gap();
      mem_never = 1'b1;
      push_acc(32'h300, 1'b0, 4'hF, 32'h0);
      bus.dm_addr = 32'h300; bus.dm_request = 1'b1;
      gap();
      gap();
      check("busy_before_reset", 32'(busy), 32'd1);
      rst = 1'b0;
      gap();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_mem_request", 32'(bus.mem_request), 32'd0);
      check("reset_dm_valid", 32'(bus.dm_valid), 32'd0);
      bus.dm_request = 1'b0;
      rst = 1'b1;
      inject_late = 1'b1;
      gap();
      inject_late = 1'b0;
      gap();
      check("late_valid_busy", 32'(busy), 32'd0);
      mem_never = 1'b0;
      push_acc(32'h100, 1'b0, 4'hF, 32'h0);
      push_acc(32'h10, 1'b0, 4'hF, 32'h0);
      push_resp(1'b1, 32'h0000_BEEF, 1'b0);
      push_resp(1'b0, 32'h0000_0093, 1'b0);
      base = resp_count;
      bus.if_addr = 32'h10; bus.if_request = 1'b1;
      bus.dm_addr = 32'h100; bus.dm_request = 1'b1;
      wait_resp(base + 1, "post_reset_data", lat);
      bus.dm_request = 1'b0;
      wait_resp(base + 2, "post_reset_fetch", lat);
      bus.if_request = 1'b0;
      repeat (3) gap();

      check("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
      check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
